// File: rtl/mux_scan_rr.sv
// Registered NCH:1 channel mux with manual select and masked round-robin scan.
// Optional MUX_SCAN_STROBE_EN adds ch_strobe, a one-cycle pulse on each channel change.
module mux_scan_rr #(
    parameter int NCH       = 4,
    parameter int W         = 4,
    parameter int DWELL_W   = 8,
    localparam int SW       = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic [SW-1:0]      sel_in,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [NCH*W-1:0]   in_bus,
    output logic [W-1:0]       out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid
`ifdef MUX_SCAN_STROBE_EN
    ,
    output logic               ch_strobe
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic [SW-1:0]      ch_q, ch_d;
    logic [W-1:0]       data_q, data_d;
    logic               valid_q, valid_d;

    logic [W-1:0]       ch_data [NCH];
    logic [SW-1:0]      next_ch;
    logic               sel_ok;
    logic               mask_none;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign ch_data[k] = in_bus[k*W +: W];
    end

    assign sel_ok    = (int'(sel_in) < NCH);
    assign mask_none = (ch_mask == '0);

    // First enabled channel strictly above ch_q, wrapping; lands on ch_q itself if it is the only one.
    always_comb begin
        int idx;
        logic found;
        next_ch = ch_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(ch_q) + i) % NCH;
            if (!found && ch_mask[idx]) begin
                next_ch = SW'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ch_d    = ch_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (ena) begin
            if (!mode) begin
                state_d = ST_MANUAL;
                count_d = '0;
                if (sel_ok) begin
                    ch_d    = sel_in;
                    data_d  = ch_data[sel_in];
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                state_d = ST_SCAN;
                if (mask_none) begin
                    count_d = '0;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    // Entering scan restarts the dwell on the current channel unless it is masked off.
                    if (state_q != ST_SCAN) begin
                        count_d = '0;
                        ch_d    = ch_mask[ch_q] ? ch_q : next_ch;
                    end else if (!ch_mask[ch_q] || count_q == dwell) begin
                        count_d = '0;
                        ch_d    = next_ch;
                    end else begin
                        count_d = count_q + DWELL_W'(1);
                    end
                    data_d = ch_data[ch_d];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

`ifdef MUX_SCAN_STROBE_EN
    // first_q makes the very first valid selection after reset pulse even if out_ch stays 0.
    logic first_q;
    logic strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= ena && valid_d && ((ch_d != ch_q) || first_q);
            if (ena && valid_d) begin
                first_q <= 1'b0;
            end
        end
    end

    assign ch_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_mux_scan_rr.sv
// Directed bench for mux_scan_rr: a rule-level model checked every cycle plus literal spot checks.
module tb_mux_scan_rr;

    localparam int NCH     = 4;
    localparam int W       = 4;
    localparam int DWELL_W = 8;
    localparam int SW      = $clog2(NCH);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic               mode;
    logic [SW-1:0]      sel_in;
    logic [DWELL_W-1:0] dwell;
    logic [NCH-1:0]     ch_mask;
    logic [NCH*W-1:0]   in_bus;
    logic [W-1:0]       out_data;
    logic [SW-1:0]      out_ch;
    logic               out_valid;
`ifdef MUX_SCAN_STROBE_EN
    logic               ch_strobe;
`endif

    int checks = 0;
    int errors = 0;

    mux_scan_rr #(.NCH(NCH), .W(W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .sel_in    (sel_in),
        .dwell     (dwell),
        .ch_mask   (ch_mask),
        .in_bus    (in_bus),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid)
`ifdef MUX_SCAN_STROBE_EN
        ,
        .ch_strobe (ch_strobe)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int           m_state;   // 0 idle, 1 manual, 2 scan
    int           m_ch;
    int           m_age;     // enabled cycles already spent on m_ch in scan
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_first;
    bit           m_strobe;

    function automatic logic [W-1:0] nib(logic [NCH*W-1:0] bus, int k);
        return bus[k*W +: W];
    endfunction

    function automatic int next_enabled(int cur, logic [NCH-1:0] m);
        int up[$];
        int res;
        for (int k = 0; k < NCH; k++) if (m[k]) up.push_back(k);
        res = up[0];
        for (int i = up.size() - 1; i >= 0; i--) if (up[i] > cur) res = up[i];
        return res;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_ch     = 0;
        m_age    = 0;
        m_data   = '0;
        m_valid  = 0;
        m_first  = 1;
        m_strobe = 0;
    endtask

    task automatic model_step();
        int  prev;
        bit  entering;
        prev = m_ch;
        if (!ena) begin
            m_strobe = 0;
        end else begin
            if (!mode) begin
                m_state = 1;
                m_age   = 0;
                if (int'(sel_in) < NCH) begin
                    m_ch    = int'(sel_in);
                    m_data  = nib(in_bus, m_ch);
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end else begin
                entering = (m_state != 2);
                m_state  = 2;
                if (ch_mask == '0) begin
                    m_age   = 0;
                    m_valid = 0;
                end else begin
                    m_valid = 1;
                    if (entering) begin
                        m_age = 0;
                        if (!ch_mask[m_ch]) m_ch = next_enabled(m_ch, ch_mask);
                    end else if (!ch_mask[m_ch] || m_age == int'(dwell)) begin
                        m_age = 0;
                        m_ch  = next_enabled(m_ch, ch_mask);
                    end else begin
                        m_age = (m_age + 1) % (1 << DWELL_W);
                    end
                    m_data = nib(in_bus, m_ch);
                end
            end
            m_strobe = m_valid && ((m_ch != prev) || m_first);
            if (m_valid) m_first = 0;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        if (rst_n) model_step();
        #2;
        if (rst_n) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_ch", 32'(out_ch), 32'(m_ch));
            check("out_valid", 32'(out_valid), 32'(m_valid));
`ifdef MUX_SCAN_STROBE_EN
            check("ch_strobe", 32'(ch_strobe), 32'(m_strobe));
`endif
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(bit e, bit md, int s, int dw, logic [NCH-1:0] mk,
                         logic [NCH*W-1:0] bus, int cycles);
        ena     = e;
        mode    = md;
        sel_in  = SW'(s);
        dwell   = DWELL_W'(dw);
        ch_mask = mk;
        in_bus  = bus;
        tick(cycles);
    endtask

    int scan_seq [15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
    int skip_seq [4]  = '{1, 3, 1, 3};
    int pulses;

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b0;
        mode    = 1'b0;
        sel_in  = '0;
        dwell   = '0;
        ch_mask = '0;
        in_bus  = 16'hD5A3;
        model_reset();
        tick(2);
        check("reset_data", 32'(out_data), 32'h0);
        check("reset_ch", 32'(out_ch), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);

        // Released with ena low: nothing moves.
        rst_n = 1'b1;
        tick(10);
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_data", 32'(out_data), 32'h0);

        // Manual select.
        ena = 1'b1; mode = 1'b0; sel_in = 2'd2;
        tick(1);
        check("man_sel2_data", 32'(out_data), 32'h5);
        check("man_sel2_ch", 32'(out_ch), 32'd2);
        check("man_sel2_valid", 32'(out_valid), 32'h1);
        sel_in = 2'd3;
        tick(1);
        check("man_sel3_data", 32'(out_data), 32'hD);
        sel_in = 2'd1;
        tick(1);
        check("man_sel1_data", 32'(out_data), 32'hA);
        sel_in = 2'd0;
        tick(1);
        check("man_sel0_data", 32'(out_data), 32'h3);

        // Scan, all channels, dwell 2: each channel held 3 cycles.
        mode = 1'b1; ch_mask = 4'b1111; dwell = 8'd2;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check("scan_ch", 32'(out_ch), 32'(scan_seq[i]));
            check("scan_data", 32'(out_data), 32'(nib(16'hD5A3, scan_seq[i])));
        end

        // Mask 1010, dwell 0: current ch0 is masked so it moves on at once.
        ch_mask = 4'b1010; dwell = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("skip_ch", 32'(out_ch), 32'(skip_seq[i]));
        end

        // Empty mask: invalid, channel and data frozen.
        ch_mask = 4'b0000;
        tick(1);
        check("empty_valid", 32'(out_valid), 32'h0);
        check("empty_ch", 32'(out_ch), 32'd3);
        tick(2);
        check("empty_ch_held", 32'(out_ch), 32'd3);
        check("empty_data_held", 32'(out_data), 32'hD);

        // Enable freeze at count 3 with dwell 5.
        ch_mask = 4'b1111; dwell = 8'd5;
        tick(3);
        check("frz_pre_ch", 32'(out_ch), 32'd3);
        check("frz_pre_valid", 32'(out_valid), 32'h1);
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("frz_ch", 32'(out_ch), 32'd3);
            check("frz_data", 32'(out_data), 32'hD);
            check("frz_valid", 32'(out_valid), 32'h1);
        end
        ena = 1'b1;
        tick(2);
        check("frz_resume_hold", 32'(out_ch), 32'd3);
        tick(1);
        check("frz_resume_adv", 32'(out_ch), 32'd0);
        check("frz_resume_data", 32'(out_data), 32'h3);

        // Mixed directed vectors, checked by the model every cycle.
        apply(1, 1, 0, 1, 4'b0110, 16'h1234, 6);
        apply(1, 1, 0, 3, 4'b0110, 16'h1234, 2);
        apply(1, 1, 0, 0, 4'b0110, 16'h1234, 3);
        apply(1, 0, 3, 0, 4'b0110, 16'h9876, 2);
        apply(1, 1, 0, 2, 4'b1001, 16'h9876, 7);
        apply(0, 1, 0, 2, 4'b1001, 16'hFFFF, 3);
        apply(1, 1, 0, 7, 4'b1111, 16'hCAFE, 4);
        apply(1, 1, 0, 1, 4'b1111, 16'hCAFE, 20);
        apply(1, 0, 1, 1, 4'b1111, 16'hCAFE, 3);
        apply(1, 1, 0, 0, 4'b0100, 16'hCAFE, 4);
        check("single_ch", 32'(out_ch), 32'd2);
        check("single_data", 32'(out_data), 32'hA);

`ifdef MUX_SCAN_STROBE_EN
        // Two enabled channels, dwell 1: a pulse every second cycle.
        apply(1, 1, 0, 1, 4'b0011, 16'hD5A3, 4);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulses += int'(ch_strobe);
        end
        check("strobe_scan_pulses", 32'(pulses), 32'd3);
`endif

        // Async reset mid-scan.
        apply(1, 1, 0, 2, 4'b1111, 16'hD5A3, 4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_data", 32'(out_data), 32'h0);
        check("async_rst_ch", 32'(out_ch), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        ena = 1'b0;
        rst_n = 1'b1;
        tick(10);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_ch", 32'(out_ch), 32'h0);

        // Resume through idle with a constant manual select.
        ena = 1'b1; mode = 1'b0; sel_in = 2'd2;
        pulses = 0;
        tick(1);
        check("resume_data", 32'(out_data), 32'h5);
        check("resume_ch", 32'(out_ch), 32'd2);
`ifdef MUX_SCAN_STROBE_EN
        pulses += int'(ch_strobe);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            pulses += int'(ch_strobe);
        end
        check("strobe_manual_pulses", 32'(pulses), 32'd1);
`else
        tick(5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_rr.md
Name: mux_scan_rr

Overview:
Parametrised successor to the team's 4:1 combinational channel mux.
- Selects one of NCH channels, each W bits wide, and drives it onto a registered output.
- Two modes:
  - Manual: the channel is chosen by the sel_in port.
  - Scan: the block round-robins automatically through channels enabled in ch_mask, dwelling a programmable number of cycles on each.
- Sits between the top-level pin wrapper (ui_in/uio_in slices) and uo_out.

Parameters:
NCH, 4, number of input channels (2..16)
W, 4, bits per channel
DWELL_W, 8, width of the dwell counter and of the dwell port
SW, $clog2(NCH), derived select width (localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low freezes all state
mode  input  1  0 = manual select, 1 = auto scan
sel_in  input  SW  manual channel select
dwell  input  DWELL_W  scan mode: cycles spent on each channel minus 1
ch_mask  input  NCH  scan mode: 1 = channel participates in rotation
in_bus  input  NCH*W  channel k occupies bits [k*W +: W]
out_data  output  W  registered selected channel data
out_ch  output  SW  index of the channel currently driven
out_valid  output  1  out_data/out_ch hold a legitimate selection

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_data=0, out_ch=0, out_valid=0.
  - Dwell counter=0, FSM=IDLE.
- FSM states:
  - IDLE: entered only from reset; leaves on the first ena=1 edge, going to MANUAL if mode=0, else SCAN.
  - MANUAL / SCAN: mode is sampled every enabled cycle; a mode change moves the FSM on that same edge.
- ena=0 in any state: all registers hold, including the counter and out_valid. Outputs stay stable.
- MANUAL:
  - sel_in < NCH: out_ch<=sel_in, out_data<=in_bus[sel_in*W +: W], out_valid<=1.
  - Latency is 1 cycle from sel_in/in_bus to outputs.
  - sel_in >= NCH (NCH not a power of 2): out_ch and out_data hold, out_valid<=0.
- SCAN:
  - out_data<=in_bus[out_ch*W +: W] every enabled cycle, so data tracks the current channel with 1-cycle latency.
  - The counter increments each enabled cycle. When count==dwell, the counter is cleared and out_ch advances to the next channel above out_ch with ch_mask=1, wrapping NCH-1 -> 0.
  - dwell=0: advance every cycle.
  - The new channel's data appears on out_data in the same cycle out_ch updates (data sampled using the next index).
  - Only one enabled channel: out_ch stays on it; the counter still runs.
  - ch_mask all zero: out_ch and out_data hold, counter cleared, out_valid<=0.
  - Otherwise out_valid<=1.
  - Current out_ch masked off mid-dwell: advance on the next enabled cycle, without waiting for the dwell to expire.
- Mode transitions:
  - MANUAL->SCAN: the counter is cleared and the rotation starts from the current out_ch.
  - SCAN->MANUAL: sel_in takes effect on the same edge.
- dwell changed mid-scan: takes effect at once against the current count. If count > new dwell, the counter wraps through 2^DWELL_W; this is a documented limitation, not an error.
- Reset asserted mid-operation: all state returns to reset values immediately. Operation resumes via IDLE.

Optional Feature:
Macro MUX_SCAN_STROBE_EN.
- Defined:
  - Adds output port ch_strobe (1 bit), reset 0.
  - ch_strobe pulses high for exactly one cycle, aligned with the edge on which out_ch takes a different value.
  - It is also high on the first valid selection after IDLE.
  - No pulse when out_ch is re-selected unchanged, or while out_valid=0.
- Undefined: the port is absent, and behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert rst_n=0 mid-scan, asynchronously -> out_data=0, out_ch=0, out_valid=0 immediately. Release with ena=0 -> outputs stay 0 for 10 cycles.
- Manual select: NCH=4, W=4, in_bus=16'hD5A3, mode=0, sel_in=2 -> one cycle later out_data=4'h5, out_ch=2, out_valid=1. Then sel_in=3 -> out_data=4'hD.
- Scan dwell: mode=1, ch_mask=4'b1111, dwell=2 -> out_ch steps 0,1,2,3,0, each held 3 cycles. out_data matches each channel nibble.
- Mask skip and empty: ch_mask=4'b1010, dwell=0 -> out_ch alternates 1,3,1,3. Then ch_mask=0 -> out_valid=0 and out_ch frozen.
- Enable freeze: in scan with dwell=5, deassert ena at count 3 for 7 cycles -> no change on any output. After re-enable, the channel advances after exactly 3 more cycles.
- Strobe (MUX_SCAN_STROBE_EN): scan with dwell=1 over 2 enabled channels -> ch_strobe high one cycle every 2 cycles. Manual with sel_in constant -> a single pulse only.
